cam_match_reader: RTL and testbench

CAM_MATCH_READER -- requirements
Module: cam_match_reader

---
 rtl/cam_match_reader.sv | 135 +++++++++++++
 tb/tb_cam_match_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cam_match_reader.sv
// cam_match_reader: walks the latched CAM match vector from lowest to highest
// row, reads each matched row through the CAM read port and presents it as a
// valid/ready beat stream. Reports the number of accepted beats and pulses
// done at the end of every readout.

module cam_match_reader #(
    parameter int unsigned RAM_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_BITS = 3
) (
    input  logic                          clka,
    input  logic                          rst,
    input  logic                          start,
    input  logic [(2**RAM_ADDR_BITS)-1:0] match_vec,
    output logic [RAM_ADDR_BITS-1:0]      cam_addr,
    input  logic [RAM_WIDTH-1:0]          cam_dout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [RAM_WIDTH-1:0]          out_data,
    output logic [RAM_ADDR_BITS-1:0]      out_addr,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic [RAM_ADDR_BITS:0]        count
);

    localparam int unsigned ROWS = 2**RAM_ADDR_BITS;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StHold = 2'd2,
        StDone = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [ROWS-1:0]          pend_q, pend_d;
    logic                     out_valid_q, out_valid_d;
    logic [RAM_WIDTH-1:0]     out_data_q, out_data_d;
    logic [RAM_ADDR_BITS-1:0] out_addr_q, out_addr_d;
    logic                     out_last_q, out_last_d;
    logic [RAM_ADDR_BITS:0]   count_q, count_d;

    logic [RAM_ADDR_BITS-1:0] low_idx;
    logic [ROWS-1:0]          low_onehot;
    logic [ROWS-1:0]          pend_clr;

    // Priority encoder: index of the lowest pending row (0 when nothing pending).
    always_comb begin
        low_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = RAM_ADDR_BITS'(i);
            end
        end
        low_onehot = ROWS'(1) << low_idx;
        pend_clr   = pend_q & ~low_onehot;
    end

    // Next-state logic for the readout FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        count_d     = count_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pend_d  = match_vec;
                    count_d = '0;
                    state_d = (match_vec != '0) ? StScan : StDone;
                end
            end
            StScan: begin
                // Capture the combinational CAM read of the lowest pending row.
                out_data_d  = cam_dout;
                out_addr_d  = low_idx;
                out_last_d  = (pend_clr == '0);
                pend_d      = pend_clr;
                out_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = count_q + (RAM_ADDR_BITS + 1)'(1);
                    state_d     = out_last_q ? StDone : StScan;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            count_q     <= count_d;
        end
    end

    // Outputs derived from state and registers.
    always_comb begin
        cam_addr  = (state_q == StScan) ? low_idx : '0;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_addr  = out_addr_q;
        out_last  = out_last_q;
        count     = count_q;
    end

endmodule

// File: tb/tb_cam_match_reader.sv
// Directed bench for cam_match_reader with a small CAM row table and a
// beat-order model derived from the applied match vector.

module tb_cam_match_reader;

    logic       clka;
    logic       rst;
    logic       start;
    logic [7:0] match_vec;
    logic [2:0] cam_addr;
    logic [7:0] cam_dout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_addr;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [3:0] count;

    logic [7:0] mem [8];

    int n_checks = 0;
    int n_pass   = 0;

    cam_match_reader #(
        .RAM_WIDTH     (8),
        .RAM_ADDR_BITS (3)
    ) dut (
        .clka      (clka),
        .rst       (rst),
        .start     (start),
        .match_vec (match_vec),
        .cam_addr  (cam_addr),
        .cam_dout  (cam_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    assign cam_dout = mem[cam_addr];

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 0);
        check({tag, "_data"}, {24'd0, out_data}, 0);
        check({tag, "_addr"}, {29'd0, out_addr}, 0);
        check({tag, "_last"}, {31'd0, out_last}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_count"}, {28'd0, count}, 0);
        check({tag, "_camaddr"}, {29'd0, cam_addr}, 0);
    endtask

    // Run one readout of mv. toggle: out_ready alternates 0/1 per cycle.
    // disturb: re-pulse start with match_vec=0x01 while busy.
    task automatic readout(input logic [7:0] mv, input bit toggle, input bit disturb,
                           input int exp_count);
        logic [7:0] remaining;
        logic [7:0] next_rem;
        logic [2:0] exp_a;
        logic [2:0] h_addr;
        logic [7:0] h_data;
        logic       h_last;
        int         beats;
        bit         held;
        bit         seen_done;
        remaining = mv;
        beats     = 0;
        held      = 0;
        seen_done = 0;
        h_addr    = '0;
        h_data    = '0;
        h_last    = 1'b0;
        @(negedge clka);
        match_vec = mv;
        start     = 1'b1;
        @(negedge clka);
        start = 1'b0;
        for (int cyc = 0; cyc < 80 && !seen_done; cyc++) begin
            if (cyc == 0) begin
                if (mv == 8'h00) check("zero_done_next_cycle", {31'd0, done}, 1);
                else check("busy_after_start", {31'd0, busy}, 1);
            end
            if (done) begin
                seen_done = 1;
                check("done_count", {28'd0, count}, exp_count);
                check("beats_accepted", beats, exp_count);
                check("rows_left", {24'd0, remaining}, 0);
            end else if (out_valid) begin
                if (held) begin
                    check("stall_addr", {29'd0, out_addr}, {29'd0, h_addr});
                    check("stall_data", {24'd0, out_data}, {24'd0, h_data});
                    check("stall_last", {31'd0, out_last}, {31'd0, h_last});
                end else if (remaining == 8'h00) begin
                    check("extra_beat", 1, 0);
                end else begin
                    exp_a = '0;
                    for (int i = 7; i >= 0; i--) if (remaining[i]) exp_a = 3'(i);
                    next_rem = remaining & ~(8'h01 << exp_a);
                    check("beat_addr", {29'd0, out_addr}, {29'd0, exp_a});
                    check("beat_data", {24'd0, out_data}, {24'd0, mem[exp_a]});
                    check("beat_last", {31'd0, out_last}, {31'd0, next_rem == 8'h00});
                    remaining = next_rem;
                    h_addr    = out_addr;
                    h_data    = out_data;
                    h_last    = out_last;
                end
                out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
                if (out_ready) begin
                    beats++;
                    held = 0;
                end else begin
                    held = 1;
                end
            end else begin
                out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
                held = 0;
            end
            if (disturb && cyc == 1) begin
                start     = 1'b1;
                match_vec = 8'h01;
            end
            if (disturb && cyc == 2) start = 1'b0;
            if (!seen_done) @(negedge clka);
        end
        if (!seen_done) check("done_timeout", 0, 1);
        @(negedge clka);
        check("done_one_cycle", {31'd0, done}, 0);
        check("idle_busy", {31'd0, busy}, 0);
        @(negedge clka);
        check("count_hold", {28'd0, count}, exp_count);
    endtask

    initial begin
        bit saw_done;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h5A; mem[3] = 8'h44;
        mem[4] = 8'h96; mem[5] = 8'hC3; mem[6] = 8'h77; mem[7] = 8'hE8;
        rst       = 1'b1;
        start     = 1'b0;
        match_vec = 8'h00;
        out_ready = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clka);
        rst = 1'b0;

        readout(8'b0010_0100, 1'b0, 1'b0, 2);
        readout(8'h00, 1'b0, 1'b0, 0);
        readout(8'hFF, 1'b1, 1'b0, 8);
        readout(8'h81, 1'b0, 1'b1, 2);

        // Abort mid-readout while a beat is stalled.
        @(negedge clka);
        out_ready = 1'b0;
        match_vec = 8'h0C;
        start     = 1'b1;
        @(negedge clka);
        start = 1'b0;
        @(negedge clka);
        check("abort_pre_valid", {31'd0, out_valid}, 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clka);
        rst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clka);
            if (done || out_valid) saw_done = 1;
        end
        check("abort_quiet", {31'd0, saw_done}, 0);
        readout(8'h10, 1'b0, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
